// File: rtl/cs_sequencer.sv
// rtl/cs_sequencer.sv - chip-select power-up hold, settle and round-robin write grant sequencer
// Optional ACTIVE watchdog enabled by defining CS_TIMEOUT_EN.
module cs_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int RST_CYCLES     = 6,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] we_en,
  input  logic [NUM_CH-1:0] flag_cs,
  output logic [2:0]        state_o,
  output logic              rst_cs,
  output logic [NUM_CH-1:0] clk_cs_en,
  output logic [SW-1:0]     ch_sel,
  output logic              start_o,
  output logic              err_o
);

  localparam int CMAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CMAX  = (CMAX0 > TIMEOUT_CYCLES) ? CMAX0 : TIMEOUT_CYCLES;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] RST_T = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SET_T = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_RELEASE = 3'd1,
    S_SETTLE  = 3'd2,
    S_ACTIVE  = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       ptr_q;
  logic [SW-1:0]       ch_sel_q;
  logic                rst_cs_q;
  logic [NUM_CH-1:0]   en_q;
  logic                start_q;

  logic [2*NUM_CH-1:0] rot;
  logic [SW:0]         idx;
  logic [SW:0]         nxt;
  logic                found;
  logic [SW-1:0]       pick;
  logic [SW-1:0]       ptr_d;
  logic [NUM_CH-1:0]   pick_oh;

  // Rotate requests so bit 0 is the search start; lowest set bit wins.
  always_comb begin
    rot   = {we_en, we_en} >> ptr_q;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = {1'b0, ptr_q} + (SW+1)'(i);
        if (idx >= (SW+1)'(NUM_CH)) idx = idx - (SW+1)'(NUM_CH);
        pick  = idx[SW-1:0];
      end
    end
    nxt = {1'b0, pick} + (SW+1)'(1);
    if (nxt >= (SW+1)'(NUM_CH)) nxt = '0;
    ptr_d   = nxt[SW-1:0];
    pick_oh = NUM_CH'(1) << pick;
  end

`ifdef CS_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_T = CW'(TIMEOUT_CYCLES - 1);
  logic err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ch_sel_q <= '0;
      rst_cs_q <= 1'b1;
      en_q     <= '0;
      start_q  <= 1'b0;
`ifdef CS_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef CS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      if (soft_rst) begin
        state_q  <= S_RESET;
        cnt_q    <= '0;
        rst_cs_q <= 1'b1;
        en_q     <= '0;
      end else begin
        case (state_q)
          S_RESET: begin
            if (cnt_q == RST_T) begin
              state_q  <= S_RELEASE;
              cnt_q    <= '0;
              rst_cs_q <= 1'b0;
              en_q     <= '1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_RELEASE: begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end
          S_SETTLE: begin
            // Counter saturates at terminal; requests are then re-evaluated each cycle.
            if (cnt_q != SET_T) begin
              cnt_q <= cnt_q + CW'(1);
            end else if (found) begin
              state_q  <= S_ACTIVE;
              cnt_q    <= '0;
              ch_sel_q <= pick;
              ptr_q    <= ptr_d;
              en_q     <= pick_oh;
              start_q  <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (!flag_cs[ch_sel_q]) begin
              state_q <= S_SETTLE;
              cnt_q   <= '0;
              en_q    <= '1;
            end
`ifdef CS_TIMEOUT_EN
            else if (cnt_q == TMO_T) begin
              state_q  <= S_ABORT;
              cnt_q    <= '0;
              rst_cs_q <= 1'b1;
              en_q     <= '0;
              err_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
`endif
          end
`ifdef CS_TIMEOUT_EN
          S_ABORT: begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            rst_cs_q <= 1'b1;
            en_q     <= '0;
          end
`endif
          default: begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            rst_cs_q <= 1'b1;
            en_q     <= '0;
          end
        endcase
      end
    end
  end

  assign state_o   = state_q;
  assign rst_cs    = rst_cs_q;
  assign clk_cs_en = en_q;
  assign ch_sel    = ch_sel_q;
  assign start_o   = start_q;

endmodule

// File: tb/tb_cs_sequencer.sv
// tb/tb_cs_sequencer.sv - directed self-checking bench for cs_sequencer
module tb_cs_sequencer;

  logic       clk;
  logic       rst_n;
  logic       soft_rst;
  logic [1:0] we_en;
  logic [1:0] flag_cs;
  logic [2:0] state_o;
  logic       rst_cs;
  logic [1:0] clk_cs_en;
  logic [0:0] ch_sel;
  logic       start_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  cs_sequencer #(
    .NUM_CH(2), .RST_CYCLES(6), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .we_en(we_en), .flag_cs(flag_cs),
    .state_o(state_o), .rst_cs(rst_cs), .clk_cs_en(clk_cs_en), .ch_sel(ch_sel),
    .start_o(start_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [2:0] st, input logic rc,
                      input logic [1:0] en, input logic st_p);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".rst_cs"}, 32'(rst_cs), 32'(rc));
    chk({tag, ".clk_cs_en"}, 32'(clk_cs_en), 32'(en));
    chk({tag, ".start"}, 32'(start_o), 32'(st_p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_sel;

  initial begin
    rst_n = 1'b0; soft_rst = 1'b0; we_en = 2'b00; flag_cs = 2'b00;
    step(); step();
    outs("reset", 3'd0, 1'b1, 2'b00, 1'b0);
    chk("reset.ch_sel", 32'(ch_sel), 32'd0);
    chk("reset.err", 32'(err_o), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      outs("hold", 3'd0, 1'b1, 2'b00, 1'b0);
    end
    step();
    outs("release", 3'd1, 1'b0, 2'b11, 1'b0);
    step();
    outs("settle0", 3'd2, 1'b0, 2'b11, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step();
      outs("idle_settle", 3'd2, 1'b0, 2'b11, 1'b0);
    end
    we_en = 2'b10; flag_cs = 2'b10;
    step();
    outs("grant1", 3'd3, 1'b0, 2'b10, 1'b1);
    chk("grant1.ch_sel", 32'(ch_sel), 32'd1);
    step();
    outs("grant1b", 3'd3, 1'b0, 2'b10, 1'b0);
    flag_cs = 2'b00;
    step();
    outs("drop1", 3'd2, 1'b0, 2'b11, 1'b0);

    // Round-robin: grants alternate 0,1,0,1 with four settle cycles between them.
    exp_sel = 1'b0;
    we_en = 2'b11;
    for (int g = 0; g < 4; g++) begin
      flag_cs = 2'b11;
      for (int i = 0; i < 3; i++) begin
        step();
        outs("rr_settle", 3'd2, 1'b0, 2'b11, 1'b0);
      end
      step();
      outs("rr_grant", 3'd3, 1'b0, exp_sel ? 2'b10 : 2'b01, 1'b1);
      chk("rr_grant.ch_sel", 32'(ch_sel), 32'(exp_sel));
      step();
      outs("rr_act2", 3'd3, 1'b0, exp_sel ? 2'b10 : 2'b01, 1'b0);
      step();
      outs("rr_act3", 3'd3, 1'b0, exp_sel ? 2'b10 : 2'b01, 1'b0);
      flag_cs = 2'b00;
      step();
      outs("rr_drop", 3'd2, 1'b0, 2'b11, 1'b0);
      exp_sel = ~exp_sel;
    end

    // Flag already low on the entry cycle: single-cycle ACTIVE.
    we_en = 2'b01; flag_cs = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      outs("min_settle", 3'd2, 1'b0, 2'b11, 1'b0);
    end
    step();
    outs("min_grant", 3'd3, 1'b0, 2'b01, 1'b1);
    chk("min_grant.ch_sel", 32'(ch_sel), 32'd0);
    step();
    outs("min_exit", 3'd2, 1'b0, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      outs("min_resettle", 3'd2, 1'b0, 2'b11, 1'b0);
    end
    flag_cs = 2'b01;
    step();
    outs("min_regrant", 3'd3, 1'b0, 2'b01, 1'b1);
    chk("min_regrant.ch_sel", 32'(ch_sel), 32'd0);

    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    outs("soft", 3'd0, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      outs("soft_hold", 3'd0, 1'b1, 2'b00, 1'b0);
    end
    step();
    outs("soft_release", 3'd1, 1'b0, 2'b11, 1'b0);
    step();
    outs("soft_settle", 3'd2, 1'b0, 2'b11, 1'b0);
    we_en = 2'b00;
    step();

    rst_n = 1'b0;
    #1;
    outs("async_rst", 3'd0, 1'b1, 2'b00, 1'b0);
    chk("async_rst.ch_sel", 32'(ch_sel), 32'd0);
    #2;
    // Pointer was 1 before reset; after reset both requests must grant channel 0.
    we_en = 2'b11; flag_cs = 2'b11;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      outs("rst2_hold", 3'd0, 1'b1, 2'b00, 1'b0);
    end
    step();
    outs("rst2_release", 3'd1, 1'b0, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      outs("rst2_settle", 3'd2, 1'b0, 2'b11, 1'b0);
    end
    step();
    outs("rst2_grant", 3'd3, 1'b0, 2'b01, 1'b1);
    chk("rst2_grant.ch_sel", 32'(ch_sel), 32'd0);

    for (int i = 0; i < 7; i++) begin
      step();
      outs("long_active", 3'd3, 1'b0, 2'b01, 1'b0);
      chk("long_active.err", 32'(err_o), 32'd0);
    end
`ifdef CS_TIMEOUT_EN
    step();
    outs("abort", 3'd4, 1'b1, 2'b00, 1'b0);
    chk("abort.err", 32'(err_o), 32'd1);
    step();
    outs("after_abort", 3'd0, 1'b1, 2'b00, 1'b0);
    chk("after_abort.err", 32'(err_o), 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      step();
      outs("no_watchdog", 3'd3, 1'b0, 2'b01, 1'b0);
      chk("no_watchdog.err", 32'(err_o), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_sequencer.md
Name: cs_sequencer

Overview:
- Parametrised chip-select power-up and arbitration sequencer for NUM_CH memory channels.
- Holds the channel reset for a programmable number of cycles, then opens the channel clock enables.
- After a programmable settle window, grants one write-requesting channel at a time, round-robin, until that channel's busy flag drops.
- Sits between the top-level control and the per-channel write engines. Drives synchronous clock enables only; it never gates clocks.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- RST_CYCLES, 6, cycles rst_cs is held after reset release (>=1).
- SETTLE_CYCLES, 4, cycles of settle window before a grant (>=1).
- TIMEOUT_CYCLES, 256, ACTIVE watchdog limit (>=2); used only with CS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- soft_rst  in  1  synchronous re-init request, active high.
- we_en  in  NUM_CH  per-channel write request, level.
- flag_cs  in  NUM_CH  per-channel busy flag, level.
- state_o  out  3  current state encoding.
- rst_cs  out  1  channel reset, high = held in reset.
- clk_cs_en  out  NUM_CH  per-channel clock enable.
- ch_sel  out  clog2(NUM_CH), min 1  granted channel index.
- start_o  out  1  one-cycle pulse on the first ACTIVE cycle.
- err_o  out  1  one-cycle timeout pulse.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- All outputs are registered and change only on clk or on rst_n assertion.
- Reset values: state_o=0 (RESET_HOLD), rst_cs=1, clk_cs_en=0, ch_sel=0, start_o=0, err_o=0, internal counter=0, round-robin pointer=0.
- States:
  - 0 RESET_HOLD: rst_cs=1, clk_cs_en=0. Counter counts 0..RST_CYCLES-1; at terminal -> RELEASE, counter cleared. RESET_HOLD lasts exactly RST_CYCLES cycles.
  - 1 RELEASE: one cycle. rst_cs=0, clk_cs_en=all ones. -> SETTLE.
  - 2 SETTLE: rst_cs=0, clk_cs_en=all ones. Counter counts 0..SETTLE_CYCLES-1 and then saturates at terminal.
    - At terminal: if we_en!=0 -> ACTIVE. ch_sel = first set bit of we_en searching upward from (last granted index+1) mod NUM_CH; after reset the search starts at 0.
    - If we_en==0 at terminal: stay in SETTLE and re-evaluate every cycle with no further wait.
  - 3 ACTIVE: clk_cs_en=one-hot(ch_sel). start_o=1 on the entry cycle only.
    - flag_cs[ch_sel] is sampled every ACTIVE cycle, including the first.
    - flag_cs[ch_sel]==0 -> SETTLE, counter cleared (full settle window again). Minimum ACTIVE length is 1 cycle.
    - we_en changes in ACTIVE are ignored.
  - 4: reachable only with CS_TIMEOUT_EN; see Optional Feature.
  - Encodings 5..7: unreachable. If ever decoded, next state = RESET_HOLD.
- soft_rst has highest priority in every state: next state RESET_HOLD, counter cleared, clk_cs_en=0, rst_cs=1 next cycle. The round-robin pointer is kept.
- rst_n asserted mid-operation forces reset values immediately (asynchronously), including the round-robin pointer.
- NUM_CH=1: ch_sel is 1 bit, held at 0.

Optional Feature:
- Macro CS_TIMEOUT_EN.
- Defined:
  - An ACTIVE-cycle counter runs while in ACTIVE.
  - If flag_cs[ch_sel] is still 1 on the TIMEOUT_CYCLES-th ACTIVE cycle -> state 4 (ABORT) for one cycle: rst_cs=1, clk_cs_en=0, err_o=1. Then -> RESET_HOLD.
  - A flag drop on the terminal cycle takes priority over the timeout.
- Undefined: no watchdog, err_o tied 0, state 4 unreachable.

Test Plan:
- Reset release with defaults -> rst_cs=1 for exactly 6 cycles. Then state_o=1 with clk_cs_en=2'b11 for 1 cycle, then state_o=2.
- SETTLE with we_en=2'b00 for 10 cycles, then we_en=2'b10 -> next cycle state_o=3, ch_sel=1, clk_cs_en=2'b10, start_o pulses once.
- we_en=2'b11 held; each grant ends with flag_cs dropping after 3 cycles -> grants alternate ch_sel 0,1,0,1. Each grant is followed by exactly 4 SETTLE cycles.
- soft_rst=1 for one cycle during ACTIVE -> next cycle state_o=0, rst_cs=1, clk_cs_en=0, then a 6-cycle hold. rst_n pulse mid-SETTLE -> outputs at reset values before the next clk edge.
- CS_TIMEOUT_EN, TIMEOUT_CYCLES=8, flag_cs held 1 -> after 8 ACTIVE cycles: state_o=4, err_o=1 for one cycle, then state_o=0.
- flag_cs[ch_sel]=0 on the ACTIVE entry cycle -> ACTIVE lasts 1 cycle, start_o=1 in that cycle, then SETTLE with counter restarted.
